wb_line_master: RTL and testbench

- Wishbone master that drives the 512-bit line-granular DDR3 Wishbone slave from a 32-bit word-access client (CPU/DMA side).
- Holds one 64-byte line buffer with a tag, a valid bit and a per-byte dirty mask.
- Word hits are served locally. A miss writes back only the dirty bytes using the byte mask, then fills the new line.
- Sits between the core-side memory port and the DDR3 slave, in the DDR3 `clkOut` (ui_clk) domain.

---
 rtl/wb_line_master_if.sv | 38 +++
 rtl/wb_line_master.sv | 272 +++++++++++++++++++++++++++
 tb/tb_wb_line_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_line_master_if.sv
// -----------------------------------------------------------------------------
// wb_line_master_if
//
// Purpose: bundles the 512-bit line-granular Wishbone link between
// wb_line_master and the DDR3 line slave.
//
// Signals:
//   wm_cyc   master -> slave  bus cycle in progress
//   wm_stb   master -> slave  transfer strobe
//   wm_we    master -> slave  1 = line write, 0 = line read
//   wm_addr  master -> slave  line byte address, bits [5:0] always 0
//   wm_dout  master -> slave  write line, byte i = bits [8i+7:8i]
//   wm_dm    master -> slave  per-byte write enable, 1 = write byte
//   wm_ack   slave -> master  transfer acknowledge
//   wm_din   slave -> master  read line, valid with wm_ack
//
// Modports: master (used by wb_line_master), slave (used by the DDR3 side).
// -----------------------------------------------------------------------------
interface wb_line_master_if;
  logic         wm_cyc;
  logic         wm_stb;
  logic         wm_we;
  logic [31:0]  wm_addr;
  logic [511:0] wm_dout;
  logic [63:0]  wm_dm;
  logic         wm_ack;
  logic [511:0] wm_din;

  modport master (
    output wm_cyc, wm_stb, wm_we, wm_addr, wm_dout, wm_dm,
    input  wm_ack, wm_din
  );

  modport slave (
    input  wm_cyc, wm_stb, wm_we, wm_addr, wm_dout, wm_dm,
    output wm_ack, wm_din
  );
endinterface

// File: rtl/wb_line_master.sv
// -----------------------------------------------------------------------------
// wb_line_master
//
// Purpose: Wishbone master that serves 32-bit word accesses from a CPU/DMA
// client out of a single 64-byte line buffer, and talks to the 512-bit
// line-granular DDR3 Wishbone slave on misses and flushes. Only dirty bytes
// are written back (byte mask on wm_dm); a fill always brings in a whole line.
// Runs entirely in the DDR3 ui_clk domain.
//
// Parameters:
//   ADDR_BITS  physical address bits decoded (tag = cpu_addr[ADDR_BITS-1:6]);
//              higher address bits are ignored and driven as 0 on wm_addr.
//
// Ports:
//   clk        single clock (DDR3 ui_clk)
//   rst        synchronous, active-high reset
//   cpu_req    word request strobe, held until cpu_ack
//   cpu_we     1 = write, 0 = read
//   cpu_addr   byte address, bits [1:0] ignored
//   cpu_din    write data
//   cpu_be     byte enables for writes
//   cpu_flush  held until cpu_ack; write back dirty bytes and invalidate
//   cpu_ack    one-cycle completion pulse
//   cpu_dout   read data, valid while cpu_ack = 1
//   bus        Wishbone line master port (wb_line_master_if.master)
//   dbg_state  current FSM state encoding
//
// Optional feature, macro WB_LINE_MASTER_STATS_EN:
//   adds stat_hit / stat_miss (32-bit, wrapping) counting accepted word
//   requests that hit or miss the line buffer. Flushes are not counted.
//   With the macro undefined the ports and counters do not exist.
// -----------------------------------------------------------------------------
module wb_line_master #(
  parameter int ADDR_BITS = 29
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_din,
  input  logic [3:0]              cpu_be,
  input  logic                    cpu_flush,
  output logic                    cpu_ack,
  output logic [31:0]             cpu_dout,
  wb_line_master_if.master        bus,
  output logic [2:0]              dbg_state
`ifdef WB_LINE_MASTER_STATS_EN
  ,
  output logic [31:0]             stat_hit,
  output logic [31:0]             stat_miss
`endif
);

  localparam int TAG_BITS = ADDR_BITS - 6;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    WB   = 3'b001,
    FILL = 3'b010,
    RESP = 3'b011,
    GAP  = 3'b100
  } state_t;

  state_t state;
  state_t state_next;

  // Line buffer and its bookkeeping
  logic [511:0]          line;
  logic [63:0]           dirty;
  logic [TAG_BITS-1:0]   tag;
  logic                  valid;

  // Request captured at acceptance; the client may change cpu_* afterwards
  logic [TAG_BITS-1:0]   req_tag;
  logic [3:0]            req_word;
  logic                  req_we;
  logic [31:0]           req_din;
  logic [3:0]            req_be;
  logic                  flush_flag;

  logic [TAG_BITS-1:0]   cpu_tag;
  logic                  hit;
  logic                  accept;
  logic                  bus_done;
  logic                  unused_addr;

  assign cpu_tag   = cpu_addr[ADDR_BITS-1:6];
  assign hit       = valid && (tag == cpu_tag);
  assign dbg_state = state;

  // The cycle in which cpu_ack is high still shows the old request on
  // cpu_req/cpu_flush, so nothing new is accepted in that cycle.
  assign accept = (state == IDLE) && !cpu_ack && (cpu_req || cpu_flush);

  // A transfer only completes while our own strobe is up; a stray ack in
  // any other state, or before the strobe rises, is ignored.
  assign bus_done = ((state == WB) || (state == FILL)) &&
                    bus.wm_cyc && bus.wm_stb && bus.wm_ack;

  assign unused_addr = ^{cpu_addr[31:ADDR_BITS], cpu_addr[1:0]};

  // Line address on the bus: tag above six zero offset bits, upper bits zero.
  function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] t);
    return 32'({t, 6'b000000});
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Flush beats a word request; a write-back is only
  // needed when some byte of the resident line is dirty.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cpu_flush) begin
            if (dirty != '0) begin
              state_next = WB;
            end
          end else if (hit) begin
            state_next = RESP;
          end else if (dirty != '0) begin
            state_next = WB;
          end else begin
            state_next = FILL;
          end
        end
      end
      WB: begin
        if (bus_done) begin
          state_next = flush_flag ? IDLE : GAP;
        end
      end
      GAP: begin
        state_next = FILL;
      end
      FILL: begin
        if (bus_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered bus outputs. The strobe is raised on the first
  // clock spent in WB/FILL and dropped on the edge that sees the ack, so the
  // bus always shows at least one idle cycle between two transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      line        <= '0;
      dirty       <= '0;
      tag         <= '0;
      valid       <= 1'b0;
      req_tag     <= '0;
      req_word    <= '0;
      req_we      <= 1'b0;
      req_din     <= '0;
      req_be      <= '0;
      flush_flag  <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_dout    <= '0;
      bus.wm_cyc  <= 1'b0;
      bus.wm_stb  <= 1'b0;
      bus.wm_we   <= 1'b0;
      bus.wm_addr <= '0;
      bus.wm_dout <= '0;
      bus.wm_dm   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_tag    <= cpu_tag;
            req_word   <= cpu_addr[5:2];
            req_we     <= cpu_we;
            req_din    <= cpu_din;
            req_be     <= cpu_be;
            flush_flag <= cpu_flush;
            // A clean flush completes right away without touching the bus
            if (cpu_flush && (dirty == '0)) begin
              valid   <= 1'b0;
              cpu_ack <= 1'b1;
            end
          end
        end
        WB: begin
          if (!bus.wm_cyc) begin
            bus.wm_cyc  <= 1'b1;
            bus.wm_stb  <= 1'b1;
            bus.wm_we   <= 1'b1;
            bus.wm_addr <= line_addr(tag);
            bus.wm_dout <= line;
            bus.wm_dm   <= dirty;
          end else if (bus_done) begin
            bus.wm_cyc <= 1'b0;
            bus.wm_stb <= 1'b0;
            bus.wm_we  <= 1'b0;
            bus.wm_dm  <= '0;
            dirty      <= '0;
            if (flush_flag) begin
              valid   <= 1'b0;
              cpu_ack <= 1'b1;
            end
          end
        end
        FILL: begin
          if (!bus.wm_cyc) begin
            bus.wm_cyc  <= 1'b1;
            bus.wm_stb  <= 1'b1;
            bus.wm_we   <= 1'b0;
            bus.wm_addr <= line_addr(req_tag);
            bus.wm_dm   <= '0;
          end else if (bus_done) begin
            bus.wm_cyc <= 1'b0;
            bus.wm_stb <= 1'b0;
            line       <= bus.wm_din;
            tag        <= req_tag;
            valid      <= 1'b1;
            dirty      <= '0;
          end
        end
        RESP: begin
          // Hits and completed fills both finish here: merge or select the word
          if (req_we) begin
            for (int i = 0; i < 4; i++) begin
              if (req_be[i]) begin
                line[{req_word, 2'(i), 3'b000} +: 8] <= req_din[8*i +: 8];
                dirty[{req_word, 2'(i)}]             <= 1'b1;
              end
            end
          end else begin
            cpu_dout <= line[{req_word, 5'b00000} +: 32];
          end
          cpu_ack <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef WB_LINE_MASTER_STATS_EN
  // Hit/miss statistics, sampled at the moment a word request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (accept && !cpu_flush) begin
      if (hit) begin
        stat_hit <= stat_hit + 32'd1;
      end else begin
        stat_miss <= stat_miss + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_line_master.sv
// -----------------------------------------------------------------------------
// tb_wb_line_master
//
// Purpose: self-checking bench for wb_line_master. A behavioural line slave
// with random ack latency backs the bus; a flat memory image kept by the bench
// predicts every read and, after a final flush, the slave's memory contents.
// Also covers cold fill, hit latency, dirty write-back mask, flush (dirty and
// clean), full-line write-back, reset during a fill and, when built with
// WB_LINE_MASTER_STATS_EN, the hit/miss counters.
// -----------------------------------------------------------------------------
module tb_wb_line_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [3:0]  cpu_be;
  logic        cpu_flush;
  logic        cpu_ack;
  logic [31:0] cpu_dout;
  logic [2:0]  dbg_state;
`ifdef WB_LINE_MASTER_STATS_EN
  logic [31:0] stat_hit;
  logic [31:0] stat_miss;
`endif

  wb_line_master_if bus ();

  wb_line_master #(.ADDR_BITS(29)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_be    (cpu_be),
    .cpu_flush (cpu_flush),
    .cpu_ack   (cpu_ack),
    .cpu_dout  (cpu_dout),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef WB_LINE_MASTER_STATS_EN
    ,
    .stat_hit  (stat_hit),
    .stat_miss (stat_miss)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory images ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [63:0] dm;
    int          start;
    int          ackc;
  } txn_t;

  txn_t         log_q[$];
  logic [511:0] slave_mem[logic [31:0]];
  logic [511:0] model_mem[logic [31:0]];
  bit           slave_hold = 1'b0;
  bit           in_txn = 1'b0;
  int           wait_cnt = 0;
  int           cycle = 0;

  // Default contents of a never-written line; 0x1000 word 2 is a marker
  function automatic logic [511:0] init_line(input logic [31:0] la);
    logic [511:0] ln;
    for (int j = 0; j < 16; j++) begin
      ln[j*32 +: 32] = la ^ (32'hA500_0000 + j * 32'h0001_0001);
    end
    if (la == 32'h0000_1000) ln[2*32 +: 32] = 32'hDEAD_BEEF;
    return ln;
  endfunction

  function automatic logic [511:0] slave_line(input logic [31:0] la);
    if (!slave_mem.exists(la)) slave_mem[la] = init_line(la);
    return slave_mem[la];
  endfunction

  // The client sees a 29-bit physical space; higher address bits alias
  function automatic logic [511:0] model_line(input logic [31:0] addr);
    logic [31:0] la;
    la = addr & 32'h1FFF_FFC0;
    return model_mem.exists(la) ? model_mem[la] : init_line(la);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    logic [511:0] ln;
    int w;
    ln = model_line(addr);
    w = int'(addr[5:2]);
    return ln[w*32 +: 32];
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] din,
                                      input logic [3:0] be);
    logic [511:0] ln;
    int w;
    ln = model_line(addr);
    w = int'(addr[5:2]);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) ln[w*32 + 8*i +: 8] = din[8*i +: 8];
    end
    model_mem[addr & 32'h1FFF_FFC0] = ln;
  endfunction

  // ---------------- line slave + bus monitor ----------------
  initial begin
    bus.wm_ack = 1'b0;
    bus.wm_din = '0;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (bus.wm_ack) begin
        bus.wm_ack = 1'b0;
      end else if (bus.wm_cyc && bus.wm_stb && !slave_hold) begin
        if (!in_txn) begin
          in_txn   = 1'b1;
          wait_cnt = $urandom_range(0, 3);
          log_q.push_back('{we: bus.wm_we, addr: bus.wm_addr, dm: bus.wm_dm,
                            start: cycle, ackc: 0});
        end
        if (wait_cnt == 0) begin
          logic [511:0] ln;
          ln = slave_line(bus.wm_addr);
          if (bus.wm_we) begin
            for (int b = 0; b < 64; b++) begin
              if (bus.wm_dm[b]) ln[8*b +: 8] = bus.wm_dout[8*b +: 8];
            end
            slave_mem[bus.wm_addr] = ln;
          end else begin
            bus.wm_din = ln;
          end
          log_q[log_q.size()-1].ackc = cycle;
          checkOutput("wm_addr_low", {58'b0, bus.wm_addr[5:0]}, 64'd0);
          checkOutput("wm_addr_high", {61'b0, bus.wm_addr[31:29]}, 64'd0);
          bus.wm_ack = 1'b1;
          in_txn     = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- client-side tasks ----------------
  // One complete request/flush handshake, followed by the mandatory idle cycle
  task automatic applyStimulus(input bit we, input bit fl, input logic [31:0] addr,
                               input logic [31:0] din, input logic [3:0] be,
                               output logic [31:0] dout, output int lat);
    cpu_req   = !fl;
    cpu_flush = fl;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_din   = din;
    cpu_be    = be;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!cpu_ack && lat < 400);
    checkOutput("ack_seen", {63'b0, cpu_ack}, 64'd1);
    dout      = cpu_dout;
    cpu_req   = 1'b0;
    cpu_flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic doAccess(input bit we, input logic [31:0] addr, input logic [31:0] din,
                          input logic [3:0] be, output int lat);
    logic [31:0] dout;
    applyStimulus(we, 1'b0, addr, din, be, dout, lat);
    if (we) model_write(addr, din, be);
    else    checkOutput($sformatf("rd_%08h", addr), {32'b0, dout}, {32'b0, model_word(addr)});
  endtask

  task automatic doFlush(output int lat);
    logic [31:0] dout;
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, dout, lat);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n0;
    logic [31:0] dout;
    logic [31:0] bases[4];

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_din = '0; cpu_be = '0; cpu_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack", {63'b0, cpu_ack}, 64'd0);
    checkOutput("rst_dout", {32'b0, cpu_dout}, 64'd0);
    checkOutput("rst_cyc_stb_we", {61'b0, bus.wm_cyc, bus.wm_stb, bus.wm_we}, 64'd0);
    checkOutput("rst_addr", {32'b0, bus.wm_addr}, 64'd0);
    checkOutput("rst_dm", bus.wm_dm, 64'd0);
    checkOutput("rst_state", {61'b0, dbg_state}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold read: one fill, no write-back
    log_q.delete();
    applyStimulus(1'b0, 1'b0, 32'h0000_1008, 32'h0, 4'h0, dout, lat);
    checkOutput("cold_dout", {32'b0, dout}, 64'h0000_0000_DEAD_BEEF);
    checkOutput("cold_ntxn", log_q.size(), 64'd1);
    if (log_q.size() >= 1) begin
      checkOutput("cold_we", {63'b0, log_q[0].we}, 64'd0);
      checkOutput("cold_addr", {32'b0, log_q[0].addr}, 64'h1000);
    end

    // Hit write then hit read: no bus traffic, two-cycle latency
    log_q.delete();
    doAccess(1'b1, 32'h0000_1004, 32'h1122_3344, 4'b0101, lat);
    checkOutput("hitw_lat", lat, 64'd2);
    doAccess(1'b0, 32'h0000_1004, 32'h0, 4'h0, lat);
    checkOutput("hitr_lat", lat, 64'd2);
    checkOutput("hit_ntxn", log_q.size(), 64'd0);

    // Dirty miss: masked write-back, idle gap, fill
    log_q.delete();
    doAccess(1'b0, 32'h0000_2000, 32'h0, 4'h0, lat);
    checkOutput("dmiss_ntxn", log_q.size(), 64'd2);
    if (log_q.size() >= 2) begin
      checkOutput("dmiss_wb_we", {63'b0, log_q[0].we}, 64'd1);
      checkOutput("dmiss_wb_addr", {32'b0, log_q[0].addr}, 64'h1000);
      checkOutput("dmiss_wb_dm", log_q[0].dm, 64'h50);
      checkOutput("dmiss_gap", {63'b0, log_q[1].start >= log_q[0].ackc + 2}, 64'd1);
      checkOutput("dmiss_fill_we", {63'b0, log_q[1].we}, 64'd0);
      checkOutput("dmiss_fill_addr", {32'b0, log_q[1].addr}, 64'h2000);
    end

    // Dirty flush, then the line must refill; clean flush has no bus cycle
    doAccess(1'b1, 32'h0000_2010, 32'hCAFE_F00D, 4'hF, lat);
    log_q.delete();
    doFlush(lat);
    checkOutput("flush_ntxn", log_q.size(), 64'd1);
    if (log_q.size() >= 1) begin
      checkOutput("flush_wb_addr", {32'b0, log_q[0].addr}, 64'h2000);
      checkOutput("flush_wb_dm", log_q[0].dm, 64'h0000_0000_000F_0000);
    end
    log_q.delete();
    doAccess(1'b0, 32'h0000_2010, 32'h0, 4'h0, lat);
    checkOutput("postflush_fill", log_q.size(), 64'd1);
    log_q.delete();
    doFlush(lat);
    checkOutput("cleanflush_lat", lat, 64'd1);
    checkOutput("cleanflush_ntxn", log_q.size(), 64'd0);

    // Full-line write-back
    doAccess(1'b0, 32'h0000_3000, 32'h0, 4'h0, lat);
    for (int w = 0; w < 16; w++) begin
      doAccess(1'b1, 32'h0000_3000 + 32'(w * 4), $urandom, 4'hF, lat);
    end
    log_q.delete();
    doFlush(lat);
    checkOutput("full_ntxn", log_q.size(), 64'd1);
    if (log_q.size() >= 1) checkOutput("full_dm", log_q[0].dm, 64'hFFFF_FFFF_FFFF_FFFF);

    // Random traffic over a few lines, one aliased through the ignored top bits
    bases[0] = 32'h0000_4000; bases[1] = 32'h0000_4040;
    bases[2] = 32'h0000_4080; bases[3] = 32'h2000_4000;
    for (int k = 0; k < 150; k++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      a  = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15) * 4);
      n0 = log_q.size();
      if (op == 0) begin
        doFlush(lat);
      end else begin
        doAccess(op > 5, a, $urandom, 4'($urandom_range(0, 15)), lat);
        if (log_q.size() == n0) checkOutput("rand_hit_lat", lat, 64'd2);
      end
    end

    // Everything written must now be in the slave
    doFlush(lat);
    foreach (bases[i]) begin
      if (i < 3) begin
        checkOutput($sformatf("mem_%08h", bases[i]),
                    {63'b0, slave_line(bases[i]) == model_line(bases[i])}, 64'd1);
      end
    end
    checkOutput("mem_1000", {63'b0, slave_line(32'h1000) == model_line(32'h1000)}, 64'd1);
    checkOutput("mem_2000", {63'b0, slave_line(32'h2000) == model_line(32'h2000)}, 64'd1);
    checkOutput("mem_3000", {63'b0, slave_line(32'h3000) == model_line(32'h3000)}, 64'd1);

    // Reset while a fill is outstanding
    doAccess(1'b0, 32'h0000_7000, 32'h0, 4'h0, lat);
    slave_hold = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7040;
    lat = 0;
    while (!bus.wm_stb && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("midfill_stb", {63'b0, bus.wm_stb}, 64'd1);
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midfill_cyc_stb", {62'b0, bus.wm_cyc, bus.wm_stb}, 64'd0);
    checkOutput("midfill_ack", {63'b0, cpu_ack}, 64'd0);
    checkOutput("midfill_state", {61'b0, dbg_state}, 64'd0);
    rst = 1'b0;
    slave_hold = 1'b0;
    in_txn = 1'b0;
    @(posedge clk);
    #1;
    log_q.delete();
    doAccess(1'b0, 32'h0000_7000, 32'h0, 4'h0, lat);
    checkOutput("midfill_refill", log_q.size(), 64'd1);
    if (log_q.size() >= 1) checkOutput("midfill_refill_addr", {32'b0, log_q[0].addr}, 64'h7000);

`ifdef WB_LINE_MASTER_STATS_EN
    pulseReset();
    checkOutput("stat_rst", {stat_hit, stat_miss}, 64'd0);
    doAccess(1'b0, 32'h0000_5000, 32'h0, 4'h0, lat);
    doAccess(1'b0, 32'h0000_5004, 32'h0, 4'h0, lat);
    doAccess(1'b1, 32'h0000_5008, 32'h5555_AAAA, 4'hF, lat);
    doAccess(1'b0, 32'h0000_5000, 32'h0, 4'h0, lat);
    doAccess(1'b0, 32'h0000_6000, 32'h0, 4'h0, lat);
    doFlush(lat);
    checkOutput("stat_hit", {32'b0, stat_hit}, 64'd3);
    checkOutput("stat_miss", {32'b0, stat_miss}, 64'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
